// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch front-end: FSM encoding,
// prefetch entry layout and the ROM window defaults used by the ROM controller.
package fetch_unit_pkg;

    localparam int PC_W    = 32;
    localparam int DATA_W  = 32;
    localparam int ENTRY_W = PC_W + DATA_W + 1;

    localparam logic [31:0] ROM_START_DEF = 32'h0000_0000;
    localparam int unsigned ROM_SIZE_DEF  = 20 * 1024;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [DATA_W-1:0] data;
        logic              fault;
    } fetch_entry_t;

    // A faulting fetch never carries bus data: the ROM leaves HRDATA undriven there.
    function automatic fetch_entry_t make_entry(input logic [PC_W-1:0]   pc,
                                                input logic [DATA_W-1:0] data,
                                                input logic              fault);
        fetch_entry_t e;
        e.pc    = pc;
        e.data  = fault ? '0 : data;
        e.fault = fault;
        return e;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO; pointers carry a wrap bit so full and empty
// are distinguishable, and flush overrides push and pop.
module fetch_fifo #(
    parameter int WIDTH = 65,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A pop frees the slot in the same cycle, so a full FIFO can still accept.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
            if (do_pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (!flush && do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    assign head = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front-end: drives the ROM address from the fetch PC,
// queues returned words (or access faults) and hands them to decode.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] ROM_START  = ROM_START_DEF,
    parameter int unsigned ROM_SIZE   = ROM_SIZE_DEF,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        CLK,
    input  logic        RST_N,
    output logic [31:0] HADDR,
    input  logic [31:0] HRDATA,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    output logic        inst_fault
);

    localparam logic [31:0] ROM_LAST_OFF = 32'(ROM_SIZE - 4);

    logic [31:0]          fetch_pc;
    logic [31:0]          pc_nxt;
    fetch_state_t         state;
    fetch_state_t         state_nxt;
    logic [32:0]          rom_off;
    logic                 fault_now;
    logic                 enq;
    logic                 deq;
    logic                 fifo_full;
    logic                 fifo_empty;
    fetch_entry_t         wr_entry;
    fetch_entry_t         head_entry;
    logic [ENTRY_W-1:0]   wr_bits;
    logic [ENTRY_W-1:0]   head_bits;

    // Offset into the ROM window; the borrow bit flags addresses below the base.
    assign rom_off   = {1'b0, fetch_pc} - {1'b0, ROM_START};
    assign fault_now = rom_off[32] || (rom_off[31:0] > ROM_LAST_OFF) || (fetch_pc[1:0] != 2'b00);

    assign deq = inst_valid && inst_ready;
    assign enq = (state == RUN) && !redirect_valid && (!fifo_full || deq);

    assign wr_entry = make_entry(fetch_pc, HRDATA, fault_now);
    assign wr_bits  = wr_entry;

    always_comb begin
        state_nxt = state;
        pc_nxt    = fetch_pc;
        if (redirect_valid) begin
            state_nxt = RUN;
            pc_nxt    = redirect_pc;
        end else if (enq) begin
            if (fault_now) state_nxt = HALT;
            else           pc_nxt    = fetch_pc + 32'd4;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            fetch_pc <= RESET_PC;
            state    <= RUN;
        end else begin
            fetch_pc <= pc_nxt;
            state    <= state_nxt;
        end
    end

    // Fetch stage -> prefetch queue boundary
    fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (CLK),
        .rst_n   (RST_N),
        .push    (enq),
        .pop     (deq),
        .flush   (redirect_valid),
        .wr_data (wr_bits),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .head    (head_bits)
    );

    assign head_entry = fetch_entry_t'(head_bits);
    assign HADDR      = fetch_pc;
    assign inst_valid = !fifo_empty;
    // Storage is not reset, so the head fields read as zero whenever nothing is queued.
    assign inst_pc    = inst_valid ? head_entry.pc   : '0;
    assign inst_data  = inst_valid ? head_entry.data : '0;
    assign inst_fault = inst_valid && head_entry.fault;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus queues expected decode transfers,
// a negedge monitor pops and compares each accepted entry.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] haddr;
    logic [31:0] hrdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        inst_fault;

    int checks   = 0;
    int failures = 0;

    fetch_entry_t exp_q[$];
    fetch_entry_t mon_e;

    always #5 clk = ~clk;

    fetch_unit dut (
        .CLK            (clk),
        .RST_N          (rst_n),
        .HADDR          (haddr),
        .HRDATA         (hrdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .inst_fault     (inst_fault)
    );

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h0000_0011;
            32'h4:   return 32'h0000_0022;
            32'h8:   return 32'h0000_0033;
            default: return {16'hC0DE, a[15:0]};
        endcase
    endfunction

    // ROM model; DEADBEEF stands in for the undriven bus outside the window.
    always_comb begin
        if (haddr <= 32'h0000_4FFC && haddr[1:0] == 2'b00) hrdata = rom_word(haddr);
        else                                               hrdata = 32'hDEAD_BEEF;
    end

    always @(negedge clk) begin
        if (rst_n && inst_valid && inst_ready && !redirect_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_xfer got pc=%h data=%h fault=%b, expected no transfer",
                         inst_pc, inst_data, inst_fault);
            end else begin
                mon_e = exp_q.pop_front();
                if (inst_pc !== mon_e.pc || inst_data !== mon_e.data || inst_fault !== mon_e.fault) begin
                    failures++;
                    $display("FAIL xfer got pc=%h data=%h fault=%b, expected pc=%h data=%h fault=%b",
                             inst_pc, inst_data, inst_fault, mon_e.pc, mon_e.data, mon_e.fault);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%b expected=%b", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] pc, input logic [31:0] data, input logic fault);
        fetch_entry_t e;
        e.pc    = pc;
        e.data  = data;
        e.fault = fault;
        exp_q.push_back(e);
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        chk("drain_left", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        rst_n          = 1'b0;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        #2;
        chk("rst_haddr", haddr, 32'h0);
        chk1("rst_valid", inst_valid, 1'b0);
        chk("rst_data", inst_data, 32'h0);
        chk("rst_pc", inst_pc, 32'h0);
        chk1("rst_fault", inst_fault, 1'b0);

        // Backpressure from reset: four entries fill, HADDR freezes at 0x10
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            chk("bp_haddr", haddr, (k < 4) ? 32'(4 * k) : 32'h10);
            if (k > 0) begin
                chk1("bp_valid", inst_valid, 1'b1);
                chk("bp_head", inst_pc, 32'h0);
            end
            tick();
        end
        for (int k = 0; k < 8; k++) push_exp(32'(4 * k), rom_word(32'(4 * k)), 1'b0);
        inst_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            chk1("drain_valid", inst_valid, 1'b1);
            chk("drain_pc", inst_pc, 32'(4 * k));
            tick();
        end
        chk("bp_done", 32'(exp_q.size()), 32'd0);

        // Redirect to 0x40, let three entries queue, then redirect to 0x100 with a pop
        inst_ready     = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        tick();
        redirect_valid = 1'b0;
        chk("rd40_haddr", haddr, 32'h40);
        chk1("rd40_valid", inst_valid, 1'b0);
        tick();
        tick();
        tick();
        chk("q3_head", inst_pc, 32'h40);
        chk("q3_haddr", haddr, 32'h4C);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        inst_ready     = 1'b1;
        tick();
        redirect_valid = 1'b0;
        chk("rd100_haddr", haddr, 32'h100);
        chk1("rd100_valid", inst_valid, 1'b0);

        // Stream up to the end of the ROM window
        for (int unsigned a = 32'h100; a <= 32'h4FFC; a += 4) push_exp(32'(a), rom_word(32'(a)), 1'b0);
        push_exp(32'h5000, 32'h0, 1'b1);
        tick();
        chk1("rd100_valid2", inst_valid, 1'b1);
        chk("rd100_pc", inst_pc, 32'h100);
        wait_drain(6000);
        for (int k = 0; k < 6; k++) begin
            chk("halt_haddr", haddr, 32'h5000);
            chk1("halt_valid", inst_valid, 1'b0);
            tick();
        end

        // Misaligned redirect: exactly one fault entry, then HALT
        push_exp(32'h102, 32'h0, 1'b1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h102;
        tick();
        redirect_valid = 1'b0;
        chk("mis_haddr", haddr, 32'h102);
        tick();
        chk1("mis_valid", inst_valid, 1'b1);
        chk1("mis_fault", inst_fault, 1'b1);
        tick();
        for (int k = 0; k < 5; k++) begin
            chk("mis_halt_haddr", haddr, 32'h102);
            chk1("mis_halt_valid", inst_valid, 1'b0);
            tick();
        end
        chk("mis_done", 32'(exp_q.size()), 32'd0);

        // Recover with a redirect to 0x0, then pulse reset mid-stream
        push_exp(32'h0, 32'h11, 1'b0);
        push_exp(32'h4, 32'h22, 1'b0);
        push_exp(32'h8, 32'h33, 1'b0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0;
        tick();
        redirect_valid = 1'b0;
        chk("rd0_haddr", haddr, 32'h0);
        chk1("rd0_valid", inst_valid, 1'b0);
        tick();
        chk("rd0_pc", inst_pc, 32'h0);
        chk("rd0_data", inst_data, 32'h11);
        tick();
        tick();
        tick();
        chk1("pre_rst_valid", inst_valid, 1'b1);
        chk("pre_rst_pc", inst_pc, 32'hC);
        rst_n = 1'b0;
        #1;
        chk1("async_rst_valid", inst_valid, 1'b0);
        chk("async_rst_haddr", haddr, 32'h0);
        chk("rd0_done", 32'(exp_q.size()), 32'd0);

        push_exp(32'h0, 32'h11, 1'b0);
        push_exp(32'h4, 32'h22, 1'b0);
        push_exp(32'h8, 32'h33, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rel_haddr0", haddr, 32'h0);
        chk1("rel_valid0", inst_valid, 1'b0);
        tick();
        chk("rel_haddr1", haddr, 32'h4);
        chk1("rel_valid1", inst_valid, 1'b1);
        chk("rel_pc1", inst_pc, 32'h0);
        tick();
        chk("rel_haddr2", haddr, 32'h8);
        tick();
        tick();
        inst_ready = 1'b0;
        chk("rel_done", 32'(exp_q.size()), 32'd0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
